// File: rtl/alu_result_sequencer.sv
// Sequences one ALU operation per request: latch operands, wait SETTLE_CYCLES, capture the
// 64-bit result and return it as one or two 32-bit beats. Optional opcode check: ALU_OPC_CHECK_EN.
module alu_result_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [4:0]  OPC_MUL       = 5'b00011,
   parameter logic [4:0]  OPC_DIV       = 5'b00100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [4:0]  alu_opcode,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [63:0] alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_hi,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_SEND_LO = 2'd2,
      S_SEND_HI = 2'd3
   } state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic        r_err;
   logic        r_req_ready;
   logic [4:0]  r_opcode;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [63:0] r_z;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_illegal;
   logic        w_two_beat;
   logic        w_one_beat;
   logic        w_capture;

`ifdef ALU_OPC_CHECK_EN
   assign w_illegal = (req_opcode < 5'd1) || (req_opcode > 5'd13);
`else
   assign w_illegal = 1'b0;
`endif

   assign w_accept   = req_valid & r_req_ready;
   assign w_two_beat = (r_opcode == OPC_MUL) || (r_opcode == OPC_DIV);
   assign w_one_beat = r_err | ~w_two_beat;
   assign w_capture  = (r_state == S_SETTLE) && (r_cnt <= 4'd1) && !r_err;

   assign req_ready  = r_req_ready;
   assign alu_opcode = r_opcode;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign hi_q       = r_hi;
   assign lo_q       = r_lo;

`ifdef ALU_OPC_CHECK_EN
   assign rsp_err = r_err & rsp_valid;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      rsp_valid    = 1'b0;
      rsp_hi       = 1'b0;
      rsp_last     = 1'b0;
      rsp_data     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_cnt <= 4'd1) w_next_state = S_SEND_LO;
         end
         S_SEND_LO: begin
            rsp_valid = 1'b1;
            rsp_data  = r_err ? 32'd0 : r_z[31:0];
            rsp_last  = w_one_beat;
            if (rsp_ready) w_next_state = w_one_beat ? S_IDLE : S_SEND_HI;
         end
         S_SEND_HI: begin
            rsp_valid = 1'b1;
            rsp_hi    = 1'b1;
            rsp_last  = 1'b1;
            rsp_data  = r_z[63:32];
            if (rsp_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // An illegal opcode runs a one-cycle settle with capture suppressed, so its
   // error beat appears one edge after accept and all data registers stay intact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_req_ready <= 1'b0;
      end else begin
         r_req_ready <= (w_next_state == S_IDLE);
         if (w_accept) begin
            r_cnt <= w_illegal ? 4'd1 : LP_SETTLE;
            r_err <= w_illegal;
         end else if ((r_state == S_SETTLE) && (r_cnt > 4'd1)) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_opcode <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_z      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_accept && !w_illegal) begin
            r_opcode <= req_opcode;
            r_a      <= req_a;
            r_b      <= req_b;
         end
         if (w_capture) begin
            r_z <= alu_c;
            if (w_two_beat) begin
               r_hi <= alu_c[63:32];
               r_lo <= alu_c[31:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Self-checking bench for alu_result_sequencer with a behavioural ALU and a beat scoreboard.
`timescale 1ns/1ps
module tb_alu_result_sequencer;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_MUL = 5'b00011;
   localparam logic [4:0] OP_DIV = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_BAD = 5'b11111;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_opcode;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  alu_opcode;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [63:0] alu_c;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_hi;
   logic        rsp_last;
   logic        rsp_err;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   typedef struct packed {
      logic [31:0] d;
      logic        h;
      logic        l;
      logic        e;
   } beat_t;

   beat_t sb[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   alu_result_sequencer #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hi(rsp_hi), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .hi_q(hi_q), .lo_q(lo_q)
   );

   always_comb begin
      alu_c = 64'd0;
      case (alu_opcode)
         OP_ADD: alu_c = {32'd0, alu_a + alu_b};
         OP_SUB: alu_c = {32'd0, alu_a - alu_b};
         OP_MUL: alu_c = {32'd0, alu_a} * {32'd0, alu_b};
         OP_DIV: alu_c = (alu_b == 0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
         OP_AND: alu_c = {32'd0, alu_a & alu_b};
         OP_OR:  alu_c = {32'd0, alu_a | alu_b};
         default: alu_c = {32'hDEADBEEF, alu_a ^ alu_b ^ 32'hA5A50000};
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic ok);
      req_opcode = op; req_a = a; req_b = b; req_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin n = i; break; end
      end
   endtask

   task automatic get_beat(output logic ok, output beat_t got);
      ok = 1'b0; got = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = '{d: rsp_data, h: rsp_hi, l: rsp_last, e: rsp_err};
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      req_opcode = '0; req_a = '0; req_b = '0;
      #2;
      checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_hi, rsp_last, rsp_err} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h hi=%b last=%b err=%b, want all 0",
                  req_ready, rsp_valid, rsp_data, rsp_hi, rsp_last, rsp_err);
      end
      checks++;
      if ({alu_opcode, alu_a, alu_b, hi_q, lo_q} !== 133'd0) begin
         errors++;
         $display("FAIL reset_regs: got opc=%h a=%h b=%h hi=%h lo=%h, want all 0",
                  alu_opcode, alu_a, alu_b, hi_q, lo_q);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_add();
      logic ok; int n; beat_t got, exp;
      sb.push_back('{d: 32'h0000000C, h: 1'b0, l: 1'b1, e: 1'b0});
      issue(OP_ADD, 32'd5, 32'd7, ok);
      wait_valid(n);
      checks++;
      if (!ok || n !== 2) begin
         errors++; $display("FAIL add_latency: got accept=%b edges=%0d want accept=1 edges=2", ok, n);
      end
      get_beat(ok, got); exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL add_beat: got ok=%b d=%h hi=%b last=%b err=%b want d=%h hi=%b last=%b err=%b",
                  ok, got.d, got.h, got.l, got.e, exp.d, exp.h, exp.l, exp.e);
      end
      checks++;
      if ({hi_q, lo_q} !== 64'd0) begin
         errors++; $display("FAIL add_hilo: got hi=%h lo=%h want 0/0", hi_q, lo_q);
      end
   endtask

   task automatic test_muldiv();
      logic ok; int n; beat_t got, exp;
      // MUL 0x10000 * 0x10000 = 0x1_00000000
      sb.push_back('{d: 32'h00000000, h: 1'b0, l: 1'b0, e: 1'b0});
      sb.push_back('{d: 32'h00000001, h: 1'b1, l: 1'b1, e: 1'b0});
      issue(OP_MUL, 32'h00010000, 32'h00010000, ok);
      wait_valid(n);
      checks++;
      if (!ok || n !== 2 || hi_q !== 32'h1 || lo_q !== 32'h0) begin
         errors++;
         $display("FAIL mul_capture: got accept=%b edges=%0d hi=%h lo=%h want 1/2/00000001/00000000",
                  ok, n, hi_q, lo_q);
      end
      for (int k = 0; k < 2; k++) begin
         get_beat(ok, got); exp = sb.pop_front();
         checks++;
         if (!ok || got !== exp) begin
            errors++;
            $display("FAIL mul_beat%0d: got ok=%b d=%h hi=%b last=%b want d=%h hi=%b last=%b",
                     k, ok, got.d, got.h, got.l, exp.d, exp.h, exp.l);
         end
      end
      // DIV 100 / 7: quotient 14 in LO, remainder 2 in HI
      sb.push_back('{d: 32'd14, h: 1'b0, l: 1'b0, e: 1'b0});
      sb.push_back('{d: 32'd2,  h: 1'b1, l: 1'b1, e: 1'b0});
      issue(OP_DIV, 32'd100, 32'd7, ok);
      for (int k = 0; k < 2; k++) begin
         get_beat(ok, got); exp = sb.pop_front();
         checks++;
         if (!ok || got !== exp) begin
            errors++;
            $display("FAIL div_beat%0d: got ok=%b d=%h hi=%b last=%b want d=%h hi=%b last=%b",
                     k, ok, got.d, got.h, got.l, exp.d, exp.h, exp.l);
         end
      end
      checks++;
      if (hi_q !== 32'd2 || lo_q !== 32'd14) begin
         errors++; $display("FAIL div_hilo: got hi=%h lo=%h want 00000002/0000000e", hi_q, lo_q);
      end
   endtask

   task automatic test_backpressure();
      logic ok; int n; int bad; beat_t got, exp;
      rsp_ready = 1'b0; bad = 0;
      sb.push_back('{d: 32'h00000007, h: 1'b0, l: 1'b1, e: 1'b0});
      issue(OP_SUB, 32'd10, 32'd3, ok);
      wait_valid(n);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h7 || rsp_last !== 1'b1 || req_ready !== 1'b0)
            bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (!ok || n !== 2 || bad != 0) begin
         errors++;
         $display("FAIL bp_hold: got accept=%b edges=%0d unstable_cycles=%0d want 1/2/0", ok, n, bad);
      end
      rsp_ready = 1'b1;
      get_beat(ok, got); exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL bp_beat: got ok=%b d=%h hi=%b last=%b want d=%h hi=%b last=%b",
                  ok, got.d, got.h, got.l, exp.d, exp.h, exp.l);
      end
      checks++;
      if (rsp_valid !== 1'b0 || hi_q !== 32'd2 || lo_q !== 32'd14) begin
         errors++;
         $display("FAIL bp_after: got vld=%b hi=%h lo=%h want 0/00000002/0000000e", rsp_valid, hi_q, lo_q);
      end
   endtask

   task automatic test_reset_midop();
      logic ok; int seen;
      issue(OP_MUL, 32'd3, 32'd4, ok);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_data, hi_q, lo_q, alu_opcode, alu_a, alu_b} !== 167'd0) begin
         errors++;
         $display("FAIL midop_reset: got vld=%b rdy=%b data=%h hi=%h lo=%h opc=%h a=%h b=%h want all 0",
                  rsp_valid, req_ready, rsp_data, hi_q, lo_q, alu_opcode, alu_a, alu_b);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (!ok || req_ready !== 1'b1) begin
         errors++; $display("FAIL midop_ready: got accept=%b rdy=%b want 1/1", ok, req_ready);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midop_no_beat: got %0d valid cycles want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic ok; beat_t got, exp;
      rsp_ready = 1'b1;
      sb.push_back('{d: 32'h000000FF, h: 1'b0, l: 1'b1, e: 1'b0});
      sb.push_back('{d: 32'h0000000F, h: 1'b0, l: 1'b1, e: 1'b0});
      req_opcode = OP_OR; req_a = 32'hF0; req_b = 32'h0F; req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      req_opcode = OP_AND; req_a = 32'hFF; req_b = 32'h0F;
      get_beat(ok, got); exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL b2b_beat0: got ok=%b d=%h last=%b want d=%h last=%b", ok, got.d, got.l, exp.d, exp.l);
      end
      checks++;
      if (req_ready !== 1'b1 || alu_opcode !== OP_OR) begin
         errors++;
         $display("FAIL b2b_gap: got rdy=%b opc=%h after handshake want 1/%h", req_ready, alu_opcode, OP_OR);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || alu_opcode !== OP_AND || alu_a !== 32'hFF) begin
         errors++;
         $display("FAIL b2b_accept: got rdy=%b opc=%h a=%h want 0/%h/000000ff", req_ready, alu_opcode, alu_a, OP_AND);
      end
      get_beat(ok, got); exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL b2b_beat1: got ok=%b d=%h last=%b want d=%h last=%b", ok, got.d, got.l, exp.d, exp.l);
      end
   endtask

   task automatic test_illegal();
      logic ok; int n; beat_t got, exp; int exp_n; logic [4:0] exp_opc;
`ifdef ALU_OPC_CHECK_EN
      sb.push_back('{d: 32'h0, h: 1'b0, l: 1'b1, e: 1'b1});
      exp_n = 1; exp_opc = OP_AND;
`else
      sb.push_back('{d: 32'hA5A50000, h: 1'b0, l: 1'b1, e: 1'b0});
      exp_n = 2; exp_opc = OP_BAD;
`endif
      issue(OP_BAD, 32'd1, 32'd1, ok);
      wait_valid(n);
      checks++;
      if (!ok || n !== exp_n || alu_opcode !== exp_opc) begin
         errors++;
         $display("FAIL illegal_timing: got accept=%b edges=%0d opc=%h want 1/%0d/%h",
                  ok, n, alu_opcode, exp_n, exp_opc);
      end
      get_beat(ok, got); exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL illegal_beat: got ok=%b d=%h hi=%b last=%b err=%b want d=%h hi=%b last=%b err=%b",
                  ok, got.d, got.h, got.l, got.e, exp.d, exp.h, exp.l, exp.e);
      end
      checks++;
      if (hi_q !== 32'd0 || lo_q !== 32'd0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL illegal_after: got hi=%h lo=%h err=%b want 0/0/0", hi_q, lo_q, rsp_err);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_muldiv();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_illegal();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_result_sequencer.md
Name: alu_result_sequencer

Overview:
- Issues one ALU operation per request and collects the ALU's 64-bit result.
- Drives opcode and operands into the combinational ALU from registers, waits a fixed settle time, then captures the {HI,LO} result into an internal Z register.
- Returns the result to the bus side as one or two 32-bit beats on a valid/ready handshake.
- Maintains the architectural HI/LO registers, which are written by MUL and DIV only.

Parameters:
- SETTLE_CYCLES, 2: cycles from accept to result capture. Legal range is 1 to 15.
- OPC_MUL, 5'b00011: multiply opcode, which produces a two-beat response and writes HI/LO.
- OPC_DIV, 5'b00100: divide opcode, which produces a two-beat response and writes HI/LO.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_opcode  in  5  ALU opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_opcode  out  5  registered opcode to the ALU.
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_c  in  64  ALU result; [63:32] is HI, [31:0] is LO.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response beat accepted.
- rsp_data  out  32  response beat data.
- rsp_hi  out  1  0 means the beat carries LO, 1 means it carries HI.
- rsp_last  out  1  final beat of the response.
- rsp_err  out  1  illegal-opcode flag (see Optional Feature).
- hi_q  out  32  architectural HI register.
- lo_q  out  32  architectural LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs go to 0: operand/opcode registers, Z, hi_q, lo_q, rsp_*.
  - req_ready is 0 while reset is asserted.
  - Reset mid-operation discards the operation; no beat is emitted after reset is released.
- Handshake: a transfer occurs on a rising edge where valid=1 and ready=1.
- IDLE:
  - req_ready=1.
  - On accept: latch req_opcode, req_a and req_b into the alu_* registers; load cnt=SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - alu_* outputs are held stable.
  - cnt decrements each cycle.
  - On the edge where cnt==1: Z <= alu_c; go to SEND_LO.
  - Capture therefore occurs exactly SETTLE_CYCLES edges after the accept edge, and rsp_valid rises on that same edge.
  - If opcode is OPC_MUL or OPC_DIV, hi_q <= alu_c[63:32] and lo_q <= alu_c[31:0] on the capture edge. Other opcodes leave hi_q/lo_q unchanged.
- SEND_LO:
  - rsp_valid=1, rsp_data=Z[31:0], rsp_hi=0.
  - rsp_last=1 unless the opcode is MUL or DIV.
  - On handshake: go to SEND_HI if the opcode is MUL or DIV, otherwise go to IDLE.
- SEND_HI:
  - rsp_valid=1, rsp_data=Z[63:32], rsp_hi=1, rsp_last=1.
  - On handshake: go to IDLE.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_hi, rsp_last and rsp_err are held constant.
  - rsp_valid never drops without a handshake.
- Throughput and overlap:
  - No overlap between operations; req_ready=0 in every state except IDLE.
  - A new request is accepted no earlier than the cycle after the final beat's handshake.
  - req_* inputs are ignored outside IDLE.
- rsp_valid, rsp_hi, rsp_last and req_ready are decoded from registered state only; there is no combinational path from any input to any output.
- Opcodes are passed to the ALU unmodified. Z capture is a full 64-bit copy with no sign or width manipulation.
- Illegal state encodings return to IDLE.

Optional Feature:
- Macro: ALU_OPC_CHECK_EN.
- Defined:
  - An accepted opcode outside 5'b00001..5'b01101 skips SETTLE.
  - Next cycle: single beat with rsp_data=0, rsp_hi=0, rsp_last=1, rsp_err=1.
  - alu_* registers, Z, hi_q and lo_q are left unchanged.
- Not defined:
  - All opcodes follow the normal path.
  - rsp_err is tied to 0.
  - The port exists in both builds.

Test Plan:
- ADD: opcode 00001, a=5, b=7, SETTLE_CYCLES=2, rsp_ready=1 -> rsp_valid rises 2 edges after accept; one beat rsp_data=0x0000000C, rsp_hi=0, rsp_last=1; hi_q=lo_q=0.
- MUL: a=0x00010000, b=0x00010000 -> beat 1 is 0x00000000 (hi=0, last=0), beat 2 is 0x00000001 (hi=1, last=1); hi_q=0x00000001, lo_q=0x00000000 from the capture edge.
- Backpressure: SUB a=10, b=3, rsp_ready held 0 for 3 cycles in SEND_LO -> rsp_valid=1 and rsp_data=0x00000007 stable all 3 cycles; req_ready=0; one beat delivered once rsp_ready=1.
- Reset mid-op: assert reset one cycle into SETTLE of MUL 3*4 -> all outputs 0 immediately, hi_q=0; after release no rsp_valid, and req_ready=1 on the first edge.
- Back-to-back: req_valid held 1 with OR 0xF0|0x0F then AND 0xFF&0x0F -> beats 0x000000FF and 0x0000000F in order; second accept occurs on the edge after the first beat's handshake.
- Illegal opcode 5'b11111, a=1, b=1:
  - With ALU_OPC_CHECK_EN: one beat, data 0, rsp_err=1, one edge after accept; alu_opcode unchanged.
  - Without: normal latency, data taken from alu_c, rsp_err=0.
